param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//   Parametrised up/down counter: next generation of the 4-bit enable counter.
//   - Configurable width and modulus, synchronous clear and load, direction
//     control, optional prescaler, terminal-count and wrap indications.
//   - General event/timer counter for control blocks: timeouts, beat counters,
//     divided-clock ticks.
// PARAMETERS
//   WIDTH      4            counter width in bits (>=1)
//   MAX_COUNT  2**WIDTH-1   highest count value; range is 0..MAX_COUNT (must fit WIDTH)
//   PRESCALE   1            enabled cycles per count step (>=1); 1 = step every enabled cycle
// PORTS
//   clk         in   1      clock, all state on rising edge
//   rst_n       in   1      asynchronous active-low reset
//   enable      in   1      count-step request (qualified by prescaler)
//   clear       in   1      synchronous clear to 0
//   load        in   1      synchronous load of load_value
//   load_value  in   WIDTH  value for load; values >MAX_COUNT are clamped to MAX_COUNT
//   up_down     in   1      1 = count up, 0 = count down
//   count       out  WIDTH  registered counter value
//   tc          out  1      combinational terminal count: count==MAX_COUNT (up) or count==0 (down)
//   wrap        out  1      registered one-cycle pulse, see BEHAVIOUR
// BEHAVIOUR
//   - Reset (rst_n=0, async): count=0, wrap=0, prescaler=0; outputs valid while in reset.
//   - Per-cycle priority: clear > load > enable > hold.
//     - clear: count<=0; prescaler<=0; wrap<=0.
//     - load: count<=min(load_value,MAX_COUNT); prescaler<=0; wrap<=0.
//     - enable:
//       - prescaler==PRESCALE-1: prescaler<=0 and a step occurs.
//       - otherwise: prescaler++ and count holds.
//     - enable=0: count and prescaler hold; wrap<=0.
//   - Step up:
//     - count<MAX_COUNT -> count+1.
//     - count==MAX_COUNT -> count<=0; wrap<=1.
//   - Step down:
//     - count>0 -> count-1.
//     - count==0 -> count<=MAX_COUNT; wrap<=1.
//   - wrap is high exactly in the cycle in which count shows the wrapped value; it is 0
//     in every other cycle.
//   - Latency: 1 clock from qualifying input to count/wrap; tc follows count and up_down
//     combinationally.
//   - up_down may change any cycle; it takes effect on the next step. Prescaler progress
//     is kept across direction changes.
//   - Arithmetic is modulo MAX_COUNT+1, never 2**WIDTH (e.g. MAX_COUNT=9: 9 -> 0 up,
//     0 -> 9 down).
//   - Mid-operation rst_n assertion overrides everything immediately; counting resumes
//     from 0 on the first enabled edge after release.
//   - Parameter errors are flagged in elaboration via a generate-time check:
//     MAX_COUNT > 2**WIDTH-1, or PRESCALE < 1.
// CONFIGURATION
//   PARAM_COUNTER_SAT_EN
//   - Defined: saturating mode.
//     - A step up at MAX_COUNT or a step down at 0 leaves count unchanged.
//     - wrap pulses 1 cycle to flag the blocked step; it means "saturation hit".
//     - All other behaviour is unchanged.
//   - Undefined: wrapping mode as described in BEHAVIOUR.
// TESTING (WIDTH=4, MAX_COUNT=9, PRESCALE=1 unless stated)
//   1. Reset with enable=1, up_down=1 -> count=0, wrap=0 during reset; 12 enabled
//      cycles after release -> 1..9,0,1,2; wrap=1 only at the 0; tc=1 only while count=9.
//   2. up_down=0 from count=0 -> 9,8,...,0,9 with wrap=1 at the 9; tc=1 while count=0.
//   3. load_value=13 with load=1 -> count=9; clear=1 together with load=1 -> count=0;
//      load together with enable -> loaded value, no step.
//   4. PRESCALE=3 with enable held -> count steps every 3rd cycle; drop enable for
//      2 cycles mid-period -> prescaler holds and phase resumes.
//   5. Assert rst_n=0 asynchronously mid-count at count=7 -> count=0 and wrap=0 before
//      the next edge; restart from 1.
//   6. PARAM_COUNTER_SAT_EN defined, count up to 9 then 2 more steps -> count stays 9,
//      wrap=1 on each blocked step; down at 0 behaves symmetrically.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with modulus, prescaler, clear/load and wrap pulse.
// Define PARAM_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module param_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             up_down_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             wrap_o
);

    localparam int unsigned      PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_COUNT);
    localparam logic [PreW-1:0]  PreLast = PreW'(PRESCALE - 1);

    if ((WIDTH == 0) || (PRESCALE == 0) ||
        (longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1))) begin : g_param_err
        $error("param_updown_counter: MAX_COUNT must fit WIDTH and PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             step;

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        wrap_d  = 1'b0;
        step    = 1'b0;

        if (clear_i) begin
            count_d = '0;
            pre_d   = '0;
        end else if (load_i) begin
            count_d = (load_value_i > MaxVal) ? MaxVal : load_value_i;
            pre_d   = '0;
        end else if (enable_i) begin
            if (pre_q == PreLast) begin
                pre_d = '0;
                step  = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        // Arithmetic is modulo MAX_COUNT+1, so the range ends are handled explicitly.
        if (step) begin
            if (up_down_i) begin
                if (count_q == MaxVal) begin
                    wrap_d = 1'b1;
`ifdef PARAM_COUNTER_SAT_EN
                    count_d = count_q;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    wrap_d = 1'b1;
`ifdef PARAM_COUNTER_SAT_EN
                    count_d = count_q;
`else
                    count_d = MaxVal;
`endif
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            pre_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;
    assign tc_o    = up_down_i ? (count_q == MaxVal) : (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: two counters (PRESCALE=1 and 3) share stimulus and are checked
// against an integer reference model; honours PARAM_COUNTER_SAT_EN like the design.
module tb_param_updown_counter;

    localparam int MAXC = 9;

    typedef struct {
        int cnt;
        int pre;
        bit wrap;
    } mstate_t;

    typedef struct {
        int c1;
        bit w1;
        bit t1;
        int c3;
        bit w3;
        bit t3;
    } exp_t;

    logic       clk_i      = 1'b0;
    logic       rst_n      = 1'b1;
    logic       enable     = 1'b0;
    logic       clear      = 1'b0;
    logic       load       = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic       up_down    = 1'b1;
    logic [3:0] count1, count3;
    logic       tc1, tc3, wrap1, wrap3;

    mstate_t s1 = '{cnt: 0, pre: 0, wrap: 1'b0};
    mstate_t s3 = '{cnt: 0, pre: 0, wrap: 1'b0};
    exp_t    q[$];
    int      checks = 0;
    int      errors = 0;

    always #5 clk_i = ~clk_i;

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(MAXC), .PRESCALE(1)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear), .load_i(load),
        .load_value_i(load_value), .up_down_i(up_down), .count_o(count1), .tc_o(tc1),
        .wrap_o(wrap1)
    );

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(MAXC), .PRESCALE(3)) dut3 (
        .clk_i(clk_i), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear), .load_i(load),
        .load_value_i(load_value), .up_down_i(up_down), .count_o(count3), .tc_o(tc3),
        .wrap_o(wrap3)
    );

    function automatic mstate_t mstep(input mstate_t s, input int p, input bit en,
                                      input bit clr, input bit ld, input int lv, input bit ud);
        mstate_t n;
        bit      stp;
        n      = s;
        n.wrap = 1'b0;
        stp    = 1'b0;
        if (clr) begin
            n.cnt = 0;
            n.pre = 0;
        end else if (ld) begin
            n.cnt = (lv > MAXC) ? MAXC : lv;
            n.pre = 0;
        end else if (en) begin
            n.pre = (s.pre + 1) % p;
            stp   = (n.pre == 0);
        end
        if (stp) begin
            if (ud) begin
                n.wrap = (s.cnt == MAXC);
`ifdef PARAM_COUNTER_SAT_EN
                n.cnt = (s.cnt == MAXC) ? MAXC : s.cnt + 1;
`else
                n.cnt = (s.cnt + 1) % (MAXC + 1);
`endif
            end else begin
                n.wrap = (s.cnt == 0);
`ifdef PARAM_COUNTER_SAT_EN
                n.cnt = (s.cnt == 0) ? 0 : s.cnt - 1;
`else
                n.cnt = (s.cnt + MAXC) % (MAXC + 1);
`endif
            end
        end
        return n;
    endfunction

    // Inputs change 1 time unit after the rising edge; asserting rst here is asynchronous.
    task automatic drive(input bit rst, input bit en, input bit clr, input bit ld,
                         input int lv, input bit ud);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_n      = rst;
        enable     = en;
        clear      = clr;
        load       = ld;
        load_value = lv[3:0];
        up_down    = ud;
        if (!rst) begin
            s1 = '{cnt: 0, pre: 0, wrap: 1'b0};
            s3 = '{cnt: 0, pre: 0, wrap: 1'b0};
        end
        e.c1 = s1.cnt;
        e.w1 = s1.wrap;
        e.t1 = ud ? (s1.cnt == MAXC) : (s1.cnt == 0);
        e.c3 = s3.cnt;
        e.w3 = s3.wrap;
        e.t3 = ud ? (s3.cnt == MAXC) : (s3.cnt == 0);
        q.push_back(e);
        if (rst) begin
            s1 = mstep(s1, 1, en, clr, ld, lv, ud);
            s3 = mstep(s3, 3, en, clr, ld, lv, ud);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count_p1", int'(count1), e.c1);
                chk("wrap_p1", int'(wrap1), int'(e.w1));
                chk("tc_p1", int'(tc1), int'(e.t1));
                chk("count_p3", int'(count3), e.c3);
                chk("wrap_p3", int'(wrap3), int'(e.w3));
                chk("tc_p3", int'(tc3), int'(e.t3));
            end
        end
    end

    initial begin : stimulus
        bit ud;
        int wait_cycles;
        #1 rst_n = 1'b0;
        repeat (3) drive(0, 1, 0, 0, 0, 1);
        repeat (12) drive(1, 1, 0, 0, 0, 1);
        drive(1, 0, 1, 0, 0, 0);
        repeat (12) drive(1, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 13, 1);
        drive(1, 0, 1, 1, 5, 1);
        drive(1, 1, 0, 1, 4, 1);
        drive(1, 0, 0, 0, 0, 1);
        repeat (4) drive(1, 1, 0, 0, 0, 1);
        repeat (2) drive(1, 0, 0, 0, 0, 1);
        repeat (5) drive(1, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 7, 1);
        drive(0, 1, 0, 0, 0, 1);
        repeat (4) drive(1, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 9, 1);
        repeat (3) drive(1, 1, 0, 0, 0, 1);
        drive(1, 0, 1, 0, 0, 0);
        repeat (3) drive(1, 1, 0, 0, 0, 0);

        ud = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) ud = ~ud;
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
                  int'($urandom_range(0, 15)), ud);
        end

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk_i);
            wait_cycles++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
